// File: rtl/video_fetch_arb_pkg.sv
// Shared video constants: DRAM slot owner encodings and video bandwidth codes,
// used by the video mode decoder and by the fetch arbiter.
package video_fetch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    VID  = 2'b01,
    CPU  = 2'b10,
    REF  = 2'b11
  } owner_t;

  localparam logic [1:0] BW_1_8 = 2'b00;
  localparam logic [1:0] BW_1_4 = 2'b01;
  localparam logic [1:0] BW_1_2 = 2'b10;
  localparam logic [1:0] BW_1_1 = 2'b11;

endpackage

// File: rtl/video_fetch_arb_slot_elig.sv
// Video slot eligibility: decides whether a slot belongs to video given the
// latched bandwidth code and the fetch window.
module video_slot_elig
  import video_fetch_arb_pkg::*;
#(
  parameter int SLOTS_LOG2 = 3
) (
  input  logic [SLOTS_LOG2-1:0] slot,
  input  logic [1:0]            bw,
  input  logic                  fetch_win,
  output logic                  eligible
);

  // Slot-pattern decode per bandwidth code; video is locked out outside the window.
  always_comb begin
    eligible = 1'b0;
    if (fetch_win) begin
      case (bw)
        BW_1_8:  eligible = (slot == '0);
        BW_1_4:  eligible = (slot[1:0] == 2'b00);
        BW_1_2:  eligible = (slot[0] == 1'b0);
        BW_1_1:  eligible = 1'b1;
        default: eligible = 1'b0;
      endcase
    end else begin
      eligible = 1'b0;
    end
  end

endmodule

// File: rtl/video_fetch_arb.sv
// DRAM slot arbiter between video fetch, CPU and refresh.
// Refresh path is present only when VIDEO_FETCH_ARB_REFRESH_EN is defined.
module video_fetch_arb
  import video_fetch_arb_pkg::*;
#(
  parameter int SLOTS_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slot_stb,
  input  logic       line_start,
  input  logic       fetch_win,
  input  logic [1:0] mode_bw,
  input  logic       cpu_req,
  input  logic       ref_req,
  output logic       vid_go,
  output logic       cpu_go,
  output logic       ref_go,
  output logic [1:0] owner
);

  logic [SLOTS_LOG2-1:0] slot_cnt;
  logic [SLOTS_LOG2-1:0] eval_slot;
  logic [1:0]            bw_q;
  logic [1:0]            eval_bw;
  logic                  eligible;
  logic                  ref_ok;
  owner_t                state;
  owner_t                state_next;
  logic                  vid_go_next;
  logic                  cpu_go_next;
  logic                  ref_go_next;
  logic                  vid_go_r;
  logic                  cpu_go_r;
  logic                  ref_go_r;

  // A slot coinciding with line_start is slot 0 of the new line, using the new line's mode.
  assign eval_slot = line_start ? '0 : slot_cnt;
  assign eval_bw   = line_start ? mode_bw : bw_q;

`ifdef VIDEO_FETCH_ARB_REFRESH_EN
  assign ref_ok = ref_req;
`else
  logic unused_ref_req;
  assign unused_ref_req = ref_req;
  assign ref_ok         = 1'b0;
`endif

  video_slot_elig #(
    .SLOTS_LOG2(SLOTS_LOG2)
  ) u_slot_elig (
    .slot      (eval_slot),
    .bw        (eval_bw),
    .fetch_win (fetch_win),
    .eligible  (eligible)
  );

  // Slot counter and per-line bandwidth latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      bw_q     <= BW_1_8;
    end else begin
      if (slot_stb) begin
        slot_cnt <= eval_slot + SLOTS_LOG2'(1);
      end else if (line_start) begin
        slot_cnt <= '0;
      end
      if (line_start) begin
        bw_q <= mode_bw;
      end
    end
  end

  // Owner state and registered grant pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vid_go_r <= 1'b0;
      cpu_go_r <= 1'b0;
      ref_go_r <= 1'b0;
    end else begin
      state    <= state_next;
      vid_go_r <= vid_go_next;
      cpu_go_r <= cpu_go_next;
      ref_go_r <= ref_go_next;
    end
  end

  // Fixed-priority winner selection at each slot strobe; state holds between strobes.
  always_comb begin
    state_next  = state;
    vid_go_next = 1'b0;
    cpu_go_next = 1'b0;
    ref_go_next = 1'b0;
    if (slot_stb) begin
      if (eligible) begin
        state_next  = VID;
        vid_go_next = 1'b1;
      end else if (cpu_req) begin
        state_next  = CPU;
        cpu_go_next = 1'b1;
      end else if (ref_ok) begin
        state_next  = REF;
        ref_go_next = 1'b1;
      end else begin
        state_next  = IDLE;
      end
    end else begin
      state_next = state;
    end
  end

  assign vid_go = vid_go_r;
  assign cpu_go = cpu_go_r;
  assign ref_go = ref_go_r;
  assign owner  = state;

endmodule

// File: doc/video_fetch_arb.md
VIDEO_FETCH_ARB -- requirements
Module: video_fetch_arb

Interface
REQ-001 The module SHALL have parameter SLOTS_LOG2, default 3, meaning log2 of the number of DRAM slots in one arbitration cycle (8 slots).
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port slot_stb, input, 1 bit: one-cycle pulse marking the start of each DRAM slot.
REQ-005 The module SHALL have port line_start, input, 1 bit: one-cycle pulse at the start of each video line.
REQ-006 The module SHALL have port fetch_win, input, 1 bit: high while the current line is inside the video fetch window.
REQ-007 The module SHALL have port mode_bw, input, 2 bits: required video bandwidth (00 = 1/8, 01 = 1/4, 10 = 1/2, 11 = 1).
REQ-008 The module SHALL have ports cpu_req and ref_req, inputs, 1 bit each: level requests from the CPU and from refresh.
REQ-009 The module SHALL have ports vid_go, cpu_go and ref_go, outputs, 1 bit each: one-cycle grant pulses.
REQ-010 The module SHALL have port owner, output, 2 bits: current slot owner (00 = idle, 01 = video, 10 = CPU, 11 = refresh).

Function
REQ-011 A SLOTS_LOG2-bit slot counter SHALL advance by 1 on each slot_stb and wrap from 7 to 0.
REQ-012 line_start SHALL clear the slot counter; when line_start and slot_stb coincide, that slot SHALL be evaluated as slot 0 and the counter SHALL become 1.
REQ-013 mode_bw SHALL be latched into bw_q only on line_start; a change of mode_bw mid-line SHALL take effect from the next line.
REQ-014 Video slot eligibility SHALL follow bw_q: 00 gives slot 0; 01 gives slots 0 and 4; 10 gives even slots; 11 gives all slots.
REQ-015 Video SHALL receive no slots while fetch_win is low.
REQ-016 Per slot, priority SHALL be video (if eligible) > CPU (cpu_req) > refresh (ref_req) > idle.
REQ-017 The owner state machine SHALL have states IDLE, VID, CPU and REF; on each slot_stb it SHALL move to the winner of REQ-016; without slot_stb it SHALL hold its state.
REQ-018 The grant output matching the new owner SHALL pulse high for exactly one cycle, in the cycle after slot_stb (1-cycle latency); all other grant outputs SHALL stay low.
REQ-019 At most one of vid_go, cpu_go and ref_go SHALL be high in any cycle.
REQ-020 An idle slot SHALL produce no grant pulse and SHALL set owner to 00.
REQ-021 A request that is deasserted before slot_stb SHALL be ignored.
REQ-022 A request that loses arbitration SHALL receive no memory of the loss; it competes again at the next slot.

Reset
REQ-023 While rst_n is low, the slot counter SHALL be 0, bw_q SHALL be 00, owner SHALL be IDLE, and every grant output SHALL be 0.
REQ-024 A reset asserted mid-slot SHALL abort any pending grant immediately.
REQ-025 After reset release, arbitration SHALL restart at the first slot_stb, with slot 0 aligned to the next line_start.

Configuration
REQ-026 With the macro VIDEO_FETCH_ARB_REFRESH_EN defined, the refresh path (ref_req, ref_go, REF state) SHALL be present as specified.
REQ-027 Without VIDEO_FETCH_ARB_REFRESH_EN, ref_req SHALL be ignored, ref_go SHALL be tied to 0, and the REF state SHALL be unreachable.

Structure
REQ-028 The owner encodings and the bandwidth codes (BW_1_8, BW_1_4, BW_1_2, BW_1_1) SHALL be defined as shared constants in the video package, so that the video mode decoder and this block use the same codes.
REQ-029 Slot eligibility SHALL be implemented in one sub-module, video_slot_elig (inputs: slot count, bw_q, fetch_win; output: eligible), and the rest SHALL stay flat.

Verification
REQ-030 Scenario: bw=00, fetch_win=1, cpu_req=1 constantly, 8 slots -> vid_go in slot 0, cpu_go in slots 1-7.
REQ-031 Scenario: bw=01, fetch_win=1, no other requests -> vid_go in slots 0 and 4, owner=00 in the remaining 6 slots.
REQ-032 Scenario: mode_bw changes 00->11 at slot 3 -> the current line keeps the 1/8 pattern, and the next line after line_start grants video all 8 slots.
REQ-033 Scenario: fetch_win=0, cpu_req=1 and ref_req=1 -> cpu_go in every slot and ref_go never.
REQ-034 Scenario: with the macro defined and only ref_req=1 -> ref_go one cycle after each slot_stb; without the macro -> ref_go stays 0.
REQ-035 Scenario: rst_n pulled low in the cycle of slot_stb -> no grant pulse, owner=00, counter=0, and bw_q=00.
